// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment glyphs, off pattern and leading-zero mask helper
package seg_pkg;

   localparam int MAX_DIGITS = 16;
   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-low {g,f,e,d,c,b,a}, indexed by nibble value (entry 15 first)
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Bit i set when nibbles digits-1..i are all zero; digit 0 always shows
   function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [MAX_DIGITS*4-1:0] word,
                                                      input int digits);
      logic all_zero;
      logic [MAX_DIGITS-1:0] mask;
      all_zero = 1'b1;
      mask = '0;
      for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
         if (i < digits) begin
            all_zero = all_zero && (word[i*4 +: 4] == 4'h0);
            mask[i] = all_zero;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to active-low seven-segment glyph
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] pattern
);

   assign pattern = SEG_TABLE[nib];

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed seven-segment scanner with frame snapshot, blanking and PWM
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SRC      = 4,
   parameter int DIV_LOG2 = 16,
   parameter int DIM_BITS = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [$clog2(SRC)-1:0]       sel,
   input  logic [SRC*DIGITS*4-1:0]      src_data,
   input  logic [DIGITS-1:0]            dp_mask,
   input  logic                         blank_lz,
   input  logic [DIM_BITS-1:0]          bright,
   input  logic                         freeze,
   output logic [DIGITS-1:0]            an,
   output logic [7:0]                   seg,
   output logic [$clog2(DIGITS)-1:0]    digit_idx
);

   localparam int IW = $clog2(DIGITS);
   localparam int SW = $clog2(SRC);
   localparam int FW = DIGITS * 4;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   logic [DIV_LOG2-1:0]     cnt;
   logic [IW-1:0]           d;
   logic [FW-1:0]           frame;
   logic [FW-1:0]           src_word;
   logic                    tick;
   logic                    lit;
   logic [DIM_BITS-1:0]     phase;
   logic [MAX_DIGITS*4-1:0] frame_ext;
   logic [DIGITS-1:0]       lz;
   logic [3:0]              nib;
   logic                    dp_bit;
   logic                    blank_bit;
   logic [6:0]              pattern;
   logic [DIGITS-1:0]       an_next;

   assign tick  = &cnt;
   assign phase = cnt[DIV_LOG2-1 -: DIM_BITS];
   assign lit   = (phase <= bright);

   always_comb begin
      src_word = '0;
      for (int k = 0; k < SRC; k++) begin
         if (sel == SW'(k)) src_word = src_data[k*FW +: FW];
      end
   end

   // Select the nibble, dp and blank flag for the digit being scanned
   always_comb begin
      frame_ext = '0;
      frame_ext[FW-1:0] = frame;
      lz = blank_lz ? DIGITS'(lz_mask(frame_ext, DIGITS)) : '0;
      nib       = '0;
      dp_bit    = 1'b0;
      blank_bit = 1'b0;
      an_next   = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (d == IW'(i)) begin
            nib        = frame[i*4 +: 4];
            dp_bit     = dp_mask[i];
            blank_bit  = lz[i];
            an_next[i] = ~lit;
         end
      end
   end

   seg_hex_decode u_dec (
      .nib     (nib),
      .pattern (pattern)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         d         <= LAST;
         frame     <= '0;
         an        <= '1;
         seg       <= SEG_OFF;
         digit_idx <= LAST;
      end else begin
         cnt <= cnt + 1'b1;
         if (tick) d <= (d == '0) ? LAST : d - 1'b1;
         // Frame boundary: last tick of digit 0 latches the next word unless frozen
         if (tick && d == '0 && !freeze) frame <= src_word;
         an        <= an_next;
         seg       <= lit ? {~dp_bit, blank_bit ? 7'h7F : pattern} : SEG_OFF;
         digit_idx <= d;
      end
   end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment display driver for board-level debug of the CPU datapath. It selects one of `SRC` hex words through `sel` and snapshots it once per scan frame, so a mid-frame change never produces a torn display. It then scans `DIGITS` common-anode digits at a prescaled rate. Over the fixed 4-digit, 4-source driver it adds leading-zero blanking, per-digit decimal points, PWM brightness, a freeze control and a synchronous reset.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned (≥2).
- `SRC`, 4: number of selectable sources (≥2).
- `DIV_LOG2`, 16: each digit slot lasts 2^DIV_LOG2 clk cycles.
- `DIM_BITS`, 3: brightness resolution (`DIM_BITS` ≤ `DIV_LOG2`).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sel`  in  $clog2(SRC)  source select.
- `src_data`  in  SRC*DIGITS*4  packed sources; source k occupies bits [k*DIGITS*4 +: DIGITS*4]; nibble 0 is the rightmost digit.
- `dp_mask`  in  DIGITS  bit i lights the decimal point of digit i.
- `blank_lz`  in  1  enable leading-zero blanking.
- `bright`  in  DIM_BITS  brightness; all-ones means full on.
- `freeze`  in  1  hold the current frame snapshot.
- `an`  out  DIGITS  anode enables, active-low, registered.
- `seg`  out  8  {dp,g,f,e,d,c,b,a}, active-low, registered.
- `digit_idx`  out  $clog2(DIGITS)  digit currently being driven.

## Operation
- **Prescaler.** `cnt` is DIV_LOG2 bits wide and free-runs, wrapping naturally. A `tick` occurs when `cnt` is all ones.
- **Scan index.** `d` starts at DIGITS-1 (leftmost). On each tick it decrements, and wraps from 0 back to DIGITS-1. It never takes a value ≥ DIGITS.
- **Frame snapshot.**
  - `frame` is DIGITS*4 bits.
  - `frame` loads the selected word from `src_data` on a tick where `d`==0, which is the frame boundary.
  - `frame` holds when `freeze`=1.
  - `dp_mask`, `blank_lz` and `bright` are sampled live and are not snapshotted.
- **Leading-zero blanking.**
  - With `blank_lz`=1, digit i is blanked when every nibble of `frame` from DIGITS-1 down to i is 0.
  - Digit 0 is never blanked, so an all-zero frame shows a single "0".
  - A blanked digit still lights its dp if its `dp_mask` bit is set.
- **Brightness.** Let `phase` = cnt[DIV_LOG2-1 -: DIM_BITS]. The anode is enabled only when `phase` ≤ `bright`. The duty cycle is therefore (bright+1)/2^DIM_BITS.
- **Drive.**
  - When the anode is enabled: `an` = ~(1<<d) and `seg` = ~{dp_mask[d], hexseg(frame nibble d)}, with segments forced off if the digit is blanked.
  - When the anode is disabled: `an` = all ones and `seg` = 8'hFF.
- **Decode.** Segment patterns cover hex 0–F with standard glyphs (lowercase b and d).

## Timing
- **Reset values** (when `rst_n`=0 at a clk edge):
  - `cnt`=0, `d`=DIGITS-1, `frame`=0.
  - `an`=all ones, `seg`=8'hFF, `digit_idx`=DIGITS-1.
- **Reset mid-scan** aborts the current frame immediately. No output glitch beyond the all-off reset state is allowed.
- **Output latency.** `an`/`seg` are registered and reflect the `cnt`/`d`/`frame` values of the previous cycle, i.e. one cycle of latency. `an` and `seg` always change on the same edge, which prevents ghosting.
- **Source-change latency.** A change on `sel` or `src_data` appears at the next frame boundary. Worst case is DIGITS*2^DIV_LOG2+1 cycles.
- **Simultaneous events.**
  - If `freeze` rises in the same cycle as the frame-boundary tick, the load is suppressed.
  - If `freeze` falls on a boundary cycle, the load occurs.
- **First frame after reset** displays `frame`=0, i.e. "0" with blanking enabled, or "0000" without.

## Structure
- A shared package `seg_pkg` holds:
  - the 16-entry active-low segment constant table;
  - the `SEG_OFF` (8'hFF) constant;
  - the function computing the leading-zero mask.
- Sub-module `seg_hex_decode` is purely combinational: 4-bit nibble in, 7-bit pattern out.
- The prescaler, scan index, snapshot and output registers live in the top module.

## Test plan
All scenarios use DIGITS=4, SRC=4, DIV_LOG2=4, DIM_BITS=2.
1. **Reset and basic scan.**
   - Stimulus: hold `rst_n`=0 for 3 cycles, then `sel`=1, source 1 = 16'h12AF, `bright`=3.
   - Required: `an`=1111 and `seg`=FF during reset. After the first frame boundary, the `an` sequence is 0111, 1011, 1101, 1110, each slot 16 cycles, showing 1, 2, A, F; `d` wraps from 0 to 3.
2. **Leading-zero blanking.**
   - Stimulus: source = 16'h0005, `blank_lz`=1, `dp_mask`=4'b0100.
   - Required: digits 3 and 2 blank, digit 2 shows only the dp (seg=8'h7F), digit 1 blank, digit 0 shows "5". A source of 16'h0000 shows only "0" on digit 0.
3. **Brightness PWM.**
   - Stimulus: `bright`=0.
   - Required: in each 16-cycle slot the anode is active for exactly 4 cycles (`phase`=0); with `bright`=2, exactly 12 cycles.
4. **Tear-free switch.**
   - Stimulus: change `sel` mid-frame from source 0 (16'h1111) to source 2 (16'h2222).
   - Required: the remaining digits of the current frame still show 1; all digits show 2 from the next frame.
5. **Freeze at the boundary.**
   - Stimulus: assert `freeze` on the frame-boundary tick cycle, then change the source.
   - Required: the display keeps the old value indefinitely. After deasserting `freeze`, the new value appears at the following boundary.
6. **Reset mid-frame.**
   - Stimulus: assert `rst_n`=0 while `d`=1.
   - Required: next cycle `an`=1111, `seg`=FF, `digit_idx`=3. Scanning restarts from digit 3 with `frame`=0.
